music_note_sequencer: RTL and testbench

MUSIC_NOTE_SEQUENCER -- requirements
Module: music_note_sequencer

---
 rtl/music_note_sequencer.sv | 172 +++++++++++++++++
 tb/tb_music_note_sequencer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/music_note_sequencer.sv
// Note-ROM sequencer: fetches 12-bit note words, plays each for a number of
// beats at a selectable tempo, and drives a DDS note code and gate.
module music_note_sequencer #(
  parameter int BEAT_N_FAST = 3125000,
  parameter int BEAT_N_SLOW = 12500000
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        start,
  input  logic        stop,
  input  logic        pause,
  input  logic        loop_en,
  input  logic [2:0]  sel,
  output logic [5:0]  rom_addr,
  input  logic [11:0] rom_data,
  output logic [7:0]  note_code,
  output logic        note_gate,
  output logic        beat_tick,
  output logic        busy,
  output logic        done
);

  // Beat counter must reach the longer of the two beat periods minus one.
  localparam int N_MAX = (BEAT_N_FAST > BEAT_N_SLOW) ? BEAT_N_FAST : BEAT_N_SLOW;
  localparam int CNT_W = $clog2(2 * (N_MAX + 1));
  localparam logic [CNT_W-1:0] LAST_FAST = CNT_W'(2 * (BEAT_N_FAST + 1) - 1);
  localparam logic [CNT_W-1:0] LAST_SLOW = CNT_W'(2 * (BEAT_N_SLOW + 1) - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_PLAY,
    S_PAUSED,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [5:0]       r_addr;
  logic [5:0]       w_addr_next;
  logic [7:0]       r_code;
  logic [7:0]       w_code_next;
  logic [CNT_W-1:0] r_beat_cnt;
  logic [CNT_W-1:0] w_beat_cnt_next;
  logic [3:0]       r_beats_left;
  logic [3:0]       w_beats_left_next;
  logic             r_fast;
  logic             w_fast_next;

  logic [CNT_W-1:0] w_last;
  logic             w_tick;
  logic             w_sel_fast;

  // Tempo in force for the current beat; sel is only sampled at beat starts.
  assign w_last     = r_fast ? LAST_FAST : LAST_SLOW;
  assign w_tick     = (r_state == S_PLAY) && (r_beat_cnt == w_last);
  assign w_sel_fast = (sel == 3'b100);

  // State register and datapath registers; reset selects slow tempo.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state      <= S_IDLE;
      r_addr       <= 6'd0;
      r_code       <= 8'd0;
      r_beat_cnt   <= '0;
      r_beats_left <= 4'd0;
      r_fast       <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_addr       <= w_addr_next;
      r_code       <= w_code_next;
      r_beat_cnt   <= w_beat_cnt_next;
      r_beats_left <= w_beats_left_next;
      r_fast       <= w_fast_next;
    end
  end

  // Next-state and datapath update; stop outranks start, start outranks pause.
  always_comb begin
    w_state_next      = r_state;
    w_addr_next       = r_addr;
    w_code_next       = r_code;
    w_beat_cnt_next   = r_beat_cnt;
    w_beats_left_next = r_beats_left;
    w_fast_next       = r_fast;

    if (stop && (r_state != S_IDLE)) begin
      w_state_next      = S_IDLE;
      w_addr_next       = 6'd0;
      w_code_next       = 8'd0;
      w_beat_cnt_next   = '0;
      w_beats_left_next = 4'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // start together with stop is treated as stop: stay idle.
          if (start && !stop) begin
            w_state_next = S_FETCH;
            w_addr_next  = 6'd0;
            w_code_next  = 8'd0;
          end
        end

        S_FETCH: begin
          // ROM word for r_addr becomes valid during DECODE.
          w_state_next = S_DECODE;
        end

        S_DECODE: begin
          if (rom_data[11]) begin
            if (loop_en) begin
              w_addr_next  = 6'd0;
              w_state_next = S_FETCH;
            end else begin
              w_state_next = S_DONE;
            end
          end else begin
            w_code_next       = rom_data[7:0];
            w_beats_left_next = {1'b0, rom_data[10:8]} + 4'd1;
            w_beat_cnt_next   = '0;
            w_fast_next       = w_sel_fast;
            w_state_next      = S_PLAY;
          end
        end

        S_PLAY: begin
          // The cycle on which pause is seen still counts as a played cycle,
          // so total gate time is unaffected by pausing.
          if (w_tick) begin
            w_beat_cnt_next   = '0;
            w_beats_left_next = r_beats_left - 4'd1;
            w_fast_next       = w_sel_fast;
            if (r_beats_left == 4'd1) begin
              w_addr_next  = r_addr + 6'd1;
              w_state_next = S_FETCH;
            end else if (pause) begin
              w_state_next = S_PAUSED;
            end
          end else begin
            w_beat_cnt_next = r_beat_cnt + CNT_W'(1);
            if (pause) begin
              w_state_next = S_PAUSED;
            end
          end
        end

        S_PAUSED: begin
          if (!pause) begin
            w_state_next = S_PLAY;
          end
        end

        S_DONE: begin
          w_state_next = S_IDLE;
        end

        default: begin
          w_state_next = S_IDLE;
        end
      endcase
    end
  end

  assign rom_addr  = r_addr;
  assign note_code = r_code;
  assign note_gate = (r_state == S_PLAY) && (r_code != 8'd0);
  assign beat_tick = w_tick;
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);

endmodule

// File: tb/tb_music_note_sequencer.sv
// Self-checking bench: songs are expanded into an expected per-cycle output
// timeline (fetch/decode gaps, beats, pauses) and compared cycle by cycle.
module tb_music_note_sequencer;

  localparam int NF     = 1;
  localparam int NS     = 4;
  localparam int P_FAST = 2 * (NF + 1);
  localparam int P_SLOW = 2 * (NS + 1);

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        start   = 1'b0;
  logic        stop    = 1'b0;
  logic        pause   = 1'b0;
  logic        loop_en = 1'b0;
  logic [2:0]  sel     = 3'b000;
  logic [5:0]  rom_addr;
  logic [11:0] rom_data;
  logic [7:0]  note_code;
  logic        note_gate;
  logic        beat_tick;
  logic        busy;
  logic        done;

  logic [11:0] rom [64];

  int n_cmp = 0;
  int n_err = 0;

  // Expected timeline: {busy, gate, tick, done, addr[5:0], code[7:0]}
  logic [17:0] exp_q [$];
  int          pause_idx;
  int          pause_len_g;
  logic [2:0]  sel_old;
  logic [2:0]  sel_new;
  int          sel_chg;

  music_note_sequencer #(
    .BEAT_N_FAST(NF),
    .BEAT_N_SLOW(NS)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .start    (start),
    .stop     (stop),
    .pause    (pause),
    .loop_en  (loop_en),
    .sel      (sel),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .note_code(note_code),
    .note_gate(note_gate),
    .beat_tick(beat_tick),
    .busy     (busy),
    .done     (done)
  );

  always #5 sys_clk = ~sys_clk;

  // Synchronous ROM: data valid one cycle after the address.
  always @(posedge sys_clk) rom_data <= rom[rom_addr];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [17:0] obs_vec();
    return {busy, note_gate, beat_tick, done, rom_addr, note_code};
  endfunction

  // sel value driven during timeline cycle idx decides the tempo of a beat
  // that starts on the following edge.
  function automatic bit tempo_fast(input int idx);
    logic [2:0] s;
    s = (idx >= sel_chg) ? sel_new : sel_old;
    return (s == 3'b100);
  endfunction

  // Expand rom[0..n_notes-1] (rom[n_notes] is the end marker) into the
  // expected timeline. Optional pause starts on play cycle pause_play.
  task automatic build_trace(input int n_notes, input int pause_play, input int pause_len);
    logic [7:0] code;
    logic [5:0] a;
    int         b;
    int         p;
    int         playcnt;
    bit         fast;
    exp_q.delete();
    pause_idx   = -1;
    pause_len_g = pause_len;
    code        = 8'd0;
    playcnt     = 0;
    for (int i = 0; i < n_notes; i++) begin
      a = 6'(i);
      exp_q.push_back({1'b1, 1'b0, 1'b0, 1'b0, a, code});
      exp_q.push_back({1'b1, 1'b0, 1'b0, 1'b0, a, code});
      fast = tempo_fast(exp_q.size() - 1);
      code = rom[i][7:0];
      b    = int'(rom[i][10:8]) + 1;
      for (int bt = 0; bt < b; bt++) begin
        p = fast ? P_FAST : P_SLOW;
        for (int c = 0; c < p; c++) begin
          exp_q.push_back({1'b1, (code != 8'd0), (c == p - 1), 1'b0, a, code});
          if (c == p - 1) fast = tempo_fast(exp_q.size() - 1);
          if (playcnt == pause_play && !(bt == b - 1 && c == p - 1)) begin
            pause_idx = exp_q.size() - 1;
            repeat (pause_len) exp_q.push_back({1'b1, 1'b0, 1'b0, 1'b0, a, code});
          end
          playcnt++;
        end
      end
    end
    a = 6'(n_notes);
    exp_q.push_back({1'b1, 1'b0, 1'b0, 1'b0, a, code});
    exp_q.push_back({1'b1, 1'b0, 1'b0, 1'b0, a, code});
    exp_q.push_back({1'b1, 1'b0, 1'b0, 1'b1, a, code});
    exp_q.push_back({1'b0, 1'b0, 1'b0, 1'b0, a, code});
  endtask

  // Pulse start, then drive pause/sel per timeline cycle and compare.
  // Stray start pulses while busy must be ignored.
  task automatic run_song(input string tag);
    bit          ok;
    logic [17:0] o;
    ok = 1'b1;
    @(posedge sys_clk); #1;
    start = 1'b1;
    pause = 1'b0;
    sel   = sel_old;
    for (int j = 0; j < exp_q.size() && ok; j++) begin
      @(posedge sys_clk); #1;
      start = (j > 0 && j < exp_q.size() - 1) ? ($urandom_range(0, 7) == 0) : 1'b0;
      pause = (pause_idx >= 0) && (j >= pause_idx) && (j < pause_idx + pause_len_g);
      sel   = (j >= sel_chg) ? sel_new : sel_old;
      @(negedge sys_clk);
      o = obs_vec();
      check_val($sformatf("%s[%0d]", tag, j), {14'd0, o}, {14'd0, exp_q[j]});
      if (o !== exp_q[j]) ok = 1'b0;
    end
    @(posedge sys_clk); #1;
    start = 1'b0;
    pause = 1'b0;
  endtask

  initial begin
    int         n;
    int         lastaddr;
    int         dn;
    bit         want_stop;
    int         seq [$];
    int         exp_seq [5];
    int         pp;

    for (int i = 0; i < 64; i++) rom[i] = 12'h800;

    // Reset state
    #2;
    check_val("reset_outputs", {14'd0, obs_vec()}, 32'd0);
    repeat (2) @(posedge sys_clk);
    #1 sys_rst = 1'b0;

    // One note, two fast beats
    rom[0]  = 12'h121;
    rom[1]  = 12'h800;
    sel_old = 3'b100; sel_new = 3'b100; sel_chg = 1 << 30;
    build_trace(1, -1, 0);
    run_song("fast_note");

    // Same note, slow tempo
    sel_old = 3'b000; sel_new = 3'b000;
    build_trace(1, -1, 0);
    run_song("slow_note");

    // Tempo change mid-beat takes effect at the next beat
    sel_old = 3'b000; sel_new = 3'b100; sel_chg = 5;
    build_trace(1, -1, 0);
    run_song("sel_change");

    // Pause for 7 cycles mid-note
    sel_old = 3'b100; sel_new = 3'b100; sel_chg = 1 << 30;
    build_trace(1, 3, 7);
    run_song("pause7");

    // start and stop together in IDLE
    @(posedge sys_clk); #1;
    start = 1'b1; stop = 1'b1;
    @(posedge sys_clk); #1;
    start = 1'b0; stop = 1'b0;
    @(negedge sys_clk);
    check_val("start_stop_idle", {31'd0, busy}, 32'd0);

    // Randomized songs
    for (int s = 0; s < 16; s++) begin
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) begin
        rom[i] = {1'b0, 3'($urandom_range(0, 7)),
                  ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255))};
      end
      rom[n]  = 12'h800 | 12'($urandom_range(0, 2047));
      sel_old = ($urandom_range(0, 1) == 1) ? 3'b100 : 3'($urandom_range(0, 7));
      sel_new = ($urandom_range(0, 1) == 1) ? 3'b100 : 3'($urandom_range(0, 7));
      sel_chg = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 60)) : (1 << 30);
      pp      = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 40)) : -1;
      build_trace(n, pp, $urandom_range(1, 8));
      run_song($sformatf("rand%0d", s));
    end

    // Looping song: addresses 0,1,2,0,1, no done, then stop mid-note
    rom[0]  = 12'h010;
    rom[1]  = 12'h011;
    rom[2]  = 12'h800;
    loop_en = 1'b1;
    sel     = 3'b100;
    exp_seq = '{0, 1, 2, 0, 1};
    seq.delete();
    lastaddr  = -1;
    dn        = 0;
    want_stop = 1'b0;
    @(posedge sys_clk); #1;
    start = 1'b1;
    for (int j = 0; j < 300 && !want_stop; j++) begin
      @(posedge sys_clk); #1;
      start = 1'b0;
      @(negedge sys_clk);
      if (done) dn++;
      if (int'(rom_addr) != lastaddr) begin
        lastaddr = int'(rom_addr);
        seq.push_back(lastaddr);
      end
      if (seq.size() == 5 && note_gate) want_stop = 1'b1;
    end
    check_val("loop_reached", {31'd0, want_stop}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      check_val($sformatf("loop_addr%0d", i), (i < seq.size()) ? seq[i] : -1, exp_seq[i]);
    end
    check_val("loop_no_done", dn, 0);
    @(posedge sys_clk); #1;
    stop = 1'b1;
    @(posedge sys_clk); #1;
    stop = 1'b0;
    @(negedge sys_clk);
    check_val("stop_idle", {14'd0, obs_vec()}, 32'd0);
    loop_en = 1'b0;

    // Asynchronous reset mid-PLAY, then restart from address 0
    rom[0] = 12'h121;
    rom[1] = 12'h800;
    sel    = 3'b100;
    @(posedge sys_clk); #1;
    start = 1'b1;
    @(posedge sys_clk); #1;
    start = 1'b0;
    for (int k = 0; k < 20 && !note_gate; k++) @(negedge sys_clk);
    check_val("rst_reach_play", {31'd0, note_gate}, 32'd1);
    @(posedge sys_clk); #2;
    sys_rst = 1'b1;
    #1;
    check_val("rst_async", {14'd0, obs_vec()}, 32'd0);
    repeat (2) @(posedge sys_clk);
    #1 sys_rst = 1'b0;
    @(negedge sys_clk);
    check_val("rst_release_idle", {31'd0, busy}, 32'd0);
    sel_old = 3'b100; sel_new = 3'b100; sel_chg = 1 << 30;
    build_trace(1, -1, 0);
    run_song("after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
